// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: EX forward-select codes,
// controller state encoding, the control bundle layout and the tag-match helper.
package fwd_hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int SRC_SEL_W  = 2;

    // Select codes shared with the EX operand muxes.
    typedef enum logic [SRC_SEL_W-1:0] {
        RS_EX = 2'b00,
        RS_ME = 2'b01,
        RS_WB = 2'b10
    } rs_src_e;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MDU_BUSY = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_me;
        logic flush_id;
        logic bubble_ex;
        logic bubble_me;
        logic bubble_wb;
    } hz_ctrl_t;

    // A producer feeds a consumer only if both are enabled, tags agree and rd is not x0.
    function automatic logic tag_hit(
        input logic [REG_ADDR_W-1:0] src_addr,
        input logic                  src_ren,
        input logic [REG_ADDR_W-1:0] rd_addr,
        input logic                  rd_wen
    );
        return src_ren && rd_wen && (rd_addr == src_addr) && (rd_addr != 5'd0);
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_sel.sv
// Per-source tag comparator: picks the youngest in-flight producer of one ID source
// and flags a load-use conflict against a load sitting in EX.
module fwd_sel
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_rs_addr,
    input  logic                  i_rs_ren,
    input  logic [REG_ADDR_W-1:0] i_ex_rd_addr,
    input  logic                  i_ex_rd_wen,
    input  logic                  i_ex_is_load,
    input  logic [REG_ADDR_W-1:0] i_me_rd_addr,
    input  logic                  i_me_rd_wen,
    output logic [SRC_SEL_W-1:0]  o_sel,
    output logic                  o_load_use
);

    logic w_ex_hit;
    logic w_me_hit;

    assign w_ex_hit = tag_hit(i_rs_addr, i_rs_ren, i_ex_rd_addr, i_ex_rd_wen);
    assign w_me_hit = tag_hit(i_rs_addr, i_rs_ren, i_me_rd_addr, i_me_rd_wen);

    // EX holds the younger producer, so it wins over ME.
    always_comb begin
        o_sel = RS_EX;
        if (w_ex_hit) begin
            o_sel = RS_ME;
        end else if (w_me_hit) begin
            o_sel = RS_WB;
        end else begin
            o_sel = RS_EX;
        end
    end

    assign o_load_use = w_ex_hit && i_ex_is_load;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Pipeline hazard controller: registered EX forward selects plus combinational
// stall/flush/bubble sequencing for MEM wait, MDU busy, branch redirect and load-use.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_ren,
    input  logic                  id_rs2_ren,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_rd_wen,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] me_rd_addr,
    input  logic                  me_rd_wen,
    input  logic                  ex_branch_taken,
    input  logic                  ex_mdu_valid,
    input  logic                  mdu_done,
    input  logic                  me_mem_req,
    input  logic                  mem_ack,
    output logic [SRC_SEL_W-1:0]  rs1_src,
    output logic [SRC_SEL_W-1:0]  rs2_src,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  stall_ex,
    output logic                  stall_me,
    output logic                  flush_id,
    output logic                  bubble_ex,
    output logic                  bubble_me,
    output logic                  bubble_wb,
    output logic [CNT_W-1:0]      stall_cnt
);

    hz_state_e             r_state;
    logic [SRC_SEL_W-1:0]  r_rs1_src;
    logic [SRC_SEL_W-1:0]  r_rs2_src;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic [SRC_SEL_W-1:0]  w_rs1_sel;
    logic [SRC_SEL_W-1:0]  w_rs2_sel;
    logic                  w_rs1_lu;
    logic                  w_rs2_lu;
    logic                  w_load_use;
    logic                  w_mem_freeze;
    logic                  w_mdu_stall;
    hz_ctrl_t              w_ctrl;

    fwd_sel u_fwd_rs1 (
        .i_rs_addr    (id_rs1_addr),
        .i_rs_ren     (id_rs1_ren),
        .i_ex_rd_addr (ex_rd_addr),
        .i_ex_rd_wen  (ex_rd_wen),
        .i_ex_is_load (ex_is_load),
        .i_me_rd_addr (me_rd_addr),
        .i_me_rd_wen  (me_rd_wen),
        .o_sel        (w_rs1_sel),
        .o_load_use   (w_rs1_lu)
    );

    fwd_sel u_fwd_rs2 (
        .i_rs_addr    (id_rs2_addr),
        .i_rs_ren     (id_rs2_ren),
        .i_ex_rd_addr (ex_rd_addr),
        .i_ex_rd_wen  (ex_rd_wen),
        .i_ex_is_load (ex_is_load),
        .i_me_rd_addr (me_rd_addr),
        .i_me_rd_wen  (me_rd_wen),
        .o_sel        (w_rs2_sel),
        .o_load_use   (w_rs2_lu)
    );

    assign w_load_use   = w_rs1_lu || w_rs2_lu;
    assign w_mem_freeze = me_mem_req && !mem_ack;

    // mdu_done releases the stall in the very cycle it arrives, in either state.
    always_comb begin
        w_mdu_stall = 1'b0;
        case (r_state)
            ST_RUN:      w_mdu_stall = ex_mdu_valid && !mdu_done;
            ST_MDU_BUSY: w_mdu_stall = !mdu_done;
            default:     w_mdu_stall = 1'b0;
        endcase
    end

    // Priority-ordered stall/flush/bubble generation; a higher cause masks all below it.
    always_comb begin
        w_ctrl = '0;
        if (w_mem_freeze) begin
            w_ctrl.stall_if  = 1'b1;
            w_ctrl.stall_id  = 1'b1;
            w_ctrl.stall_ex  = 1'b1;
            w_ctrl.stall_me  = 1'b1;
            w_ctrl.bubble_wb = 1'b1;
        end else if (w_mdu_stall) begin
            w_ctrl.stall_if  = 1'b1;
            w_ctrl.stall_id  = 1'b1;
            w_ctrl.stall_ex  = 1'b1;
            w_ctrl.bubble_me = 1'b1;
        end else if (ex_branch_taken) begin
            w_ctrl.flush_id  = 1'b1;
            w_ctrl.bubble_ex = 1'b1;
        end else if (w_load_use) begin
            w_ctrl.stall_if  = 1'b1;
            w_ctrl.stall_id  = 1'b1;
            w_ctrl.bubble_ex = 1'b1;
        end else begin
            w_ctrl = '0;
        end
    end

    assign stall_if  = w_ctrl.stall_if;
    assign stall_id  = w_ctrl.stall_id;
    assign stall_ex  = w_ctrl.stall_ex;
    assign stall_me  = w_ctrl.stall_me;
    assign flush_id  = w_ctrl.flush_id;
    assign bubble_ex = w_ctrl.bubble_ex;
    assign bubble_me = w_ctrl.bubble_me;
    assign bubble_wb = w_ctrl.bubble_wb;

    // MDU occupancy tracker; a MEM freeze blocks entry but never blocks the exit on mdu_done.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (ex_mdu_valid && !mdu_done && !w_mem_freeze) begin
                        r_state <= ST_MDU_BUSY;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_MDU_BUSY: begin
                    if (mdu_done) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_MDU_BUSY;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // EX forward selects travel with the operand registers: hold, bubble or advance.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rs1_src <= RS_EX;
            r_rs2_src <= RS_EX;
        end else if (w_ctrl.stall_ex) begin
            r_rs1_src <= r_rs1_src;
            r_rs2_src <= r_rs2_src;
        end else if (w_ctrl.bubble_ex) begin
            r_rs1_src <= RS_EX;
            r_rs2_src <= RS_EX;
        end else begin
            r_rs1_src <= w_rs1_sel;
            r_rs2_src <= w_rs2_sel;
        end
    end

    // Free-running count of fetch-stall cycles, wrapping naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (w_ctrl.stall_if) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign rs1_src   = r_rs1_src;
    assign rs2_src   = r_rs2_src;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural reference model.
module tb_fwd_hazard_ctrl;

    localparam int CW = 4;

    logic          clock;
    logic          reset_n;
    logic [4:0]    id_rs1_addr, id_rs2_addr, ex_rd_addr, me_rd_addr;
    logic          id_rs1_ren, id_rs2_ren, ex_rd_wen, ex_is_load, me_rd_wen;
    logic          ex_branch_taken, ex_mdu_valid, mdu_done, me_mem_req, mem_ack;
    logic [1:0]    rs1_src, rs2_src;
    logic          stall_if, stall_id, stall_ex, stall_me;
    logic          flush_id, bubble_ex, bubble_me, bubble_wb;
    logic [CW-1:0] stall_cnt;

    int n_cmp;
    int n_err;

    // Reference model state
    bit m_busy;
    int m_sel1, m_sel2, m_cnt;

    fwd_hazard_ctrl #(.CNT_W(CW)) dut (
        .clock(clock), .reset_n(reset_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
        .ex_rd_addr(ex_rd_addr), .ex_rd_wen(ex_rd_wen), .ex_is_load(ex_is_load),
        .me_rd_addr(me_rd_addr), .me_rd_wen(me_rd_wen),
        .ex_branch_taken(ex_branch_taken),
        .ex_mdu_valid(ex_mdu_valid), .mdu_done(mdu_done),
        .me_mem_req(me_mem_req), .mem_ack(mem_ack),
        .rs1_src(rs1_src), .rs2_src(rs2_src),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_me(stall_me),
        .flush_id(flush_id), .bubble_ex(bubble_ex), .bubble_me(bubble_me), .bubble_wb(bubble_wb),
        .stall_cnt(stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Which stage the operand comes from: 0 = regfile/EX, 1 = EX result, 2 = ME result.
    function automatic int ref_fwd(input bit ren, input int a);
        if (!ren || a == 0) return 0;
        if (ex_rd_wen && ex_rd_addr == a) return 1;
        if (me_rd_wen && me_rd_addr == a) return 2;
        return 0;
    endfunction

    // Expected {stall_if,stall_id,stall_ex,stall_me,flush_id,bubble_ex,bubble_me,bubble_wb}.
    function automatic int ref_ctrl();
        bit freeze, mdu, lu;
        freeze = me_mem_req && !mem_ack;
        mdu    = !mdu_done && (m_busy || ex_mdu_valid);
        lu     = ex_is_load && ex_rd_wen && ex_rd_addr != 0 &&
                 ((id_rs1_ren && id_rs1_addr == ex_rd_addr) ||
                  (id_rs2_ren && id_rs2_addr == ex_rd_addr));
        if (freeze)               return 'b1111_0001;
        else if (mdu)             return 'b1110_0010;
        else if (ex_branch_taken) return 'b0000_1100;
        else if (lu)              return 'b1100_0100;
        else                      return 0;
    endfunction

    function automatic int obs_ctrl();
        return {24'd0, stall_if, stall_id, stall_ex, stall_me,
                flush_id, bubble_ex, bubble_me, bubble_wb};
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_sel1 = 0; m_sel2 = 0; m_cnt = 0;
    endtask

    task automatic set_idle();
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rs1_ren = 1'b0; id_rs2_ren = 1'b0;
        ex_rd_addr = 5'd0; ex_rd_wen = 1'b0; ex_is_load = 1'b0;
        me_rd_addr = 5'd0; me_rd_wen = 1'b0; ex_branch_taken = 1'b0;
        ex_mdu_valid = 1'b0; mdu_done = 1'b0; me_mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    // Inputs are set at a negedge; check mid-cycle, advance model at posedge, return at negedge.
    task automatic cycle();
        int e, f1, f2;
        bit freeze;
        #1;
        e  = ref_ctrl();
        f1 = ref_fwd(id_rs1_ren, int'(id_rs1_addr));
        f2 = ref_fwd(id_rs2_ren, int'(id_rs2_addr));
        freeze = me_mem_req && !mem_ack;
        check_val("ctrl", obs_ctrl(), e);
        check_val("rs1_src", int'(rs1_src), m_sel1);
        check_val("rs2_src", int'(rs2_src), m_sel2);
        check_val("stall_cnt", int'(stall_cnt), m_cnt);
        @(posedge clock);
        if (!e[5]) begin
            m_sel1 = e[2] ? 0 : f1;
            m_sel2 = e[2] ? 0 : f2;
        end
        if (e[7]) m_cnt = (m_cnt + 1) % (1 << CW);
        if (!m_busy) m_busy = ex_mdu_valid && !mdu_done && !freeze;
        else         m_busy = !mdu_done;
        @(negedge clock);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        set_idle();
        model_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check_val("rst_rs1", int'(rs1_src), 0);
        check_val("rst_cnt", int'(stall_cnt), 0);
        check_val("rst_ctrl", obs_ctrl(), 0);
        @(negedge clock);
        reset_n = 1'b1;
        cycle();

        // add x5 in EX, sub reads x5 as rs2
        ex_rd_addr = 5'd5; ex_rd_wen = 1'b1; id_rs2_addr = 5'd5; id_rs2_ren = 1'b1;
        cycle();
        check_val("fwd_ex", int'(rs2_src), 1);
        ex_rd_wen = 1'b0; me_rd_addr = 5'd5; me_rd_wen = 1'b1;
        cycle();
        check_val("fwd_me", int'(rs2_src), 2);
        ex_rd_wen = 1'b1;
        cycle();
        check_val("fwd_both", int'(rs2_src), 1);
        ex_rd_addr = 5'd0; me_rd_addr = 5'd0; id_rs2_addr = 5'd0;
        cycle();
        check_val("fwd_x0", int'(rs2_src), 0);

        // load-use on x6
        set_idle();
        ex_rd_addr = 5'd6; ex_rd_wen = 1'b1; ex_is_load = 1'b1;
        id_rs1_addr = 5'd6; id_rs1_ren = 1'b1;
        #1;
        check_val("lu_stall_if", int'(stall_if), 1);
        check_val("lu_bubble_ex", int'(bubble_ex), 1);
        #1;
        cycle();
        check_val("lu_cnt", int'(stall_cnt), 1);
        ex_rd_wen = 1'b0; ex_is_load = 1'b0; me_rd_addr = 5'd6; me_rd_wen = 1'b1;
        #1;
        check_val("lu_release", int'(stall_if), 0);
        cycle();
        check_val("lu_wb_sel", int'(rs1_src), 2);

        // load-use together with redirect
        set_idle();
        ex_rd_addr = 5'd6; ex_rd_wen = 1'b1; ex_is_load = 1'b1;
        id_rs1_addr = 5'd6; id_rs1_ren = 1'b1; ex_branch_taken = 1'b1;
        #1;
        check_val("br_lu_if", int'(stall_if), 0);
        check_val("br_lu_flush", int'(flush_id), 1);
        cycle();

        // MDU busy for 4 cycles, done in the 5th
        set_idle();
        ex_mdu_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val("mdu_stall_ex", int'(stall_ex), 1);
            check_val("mdu_bubble_me", int'(bubble_me), 1);
            cycle();
        end
        mdu_done = 1'b1;
        #1;
        check_val("mdu_release", int'(stall_ex), 0);
        cycle();
        set_idle();
        #1;
        check_val("mdu_run", int'(stall_ex), 0);
        cycle();

        // MEM freeze with an RS_ME select pending, then reset mid-wait in MDU_BUSY
        ex_rd_addr = 5'd7; ex_rd_wen = 1'b1; id_rs1_addr = 5'd7; id_rs1_ren = 1'b1;
        cycle();
        ex_mdu_valid = 1'b1;
        cycle();
        me_mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("frz_stall_me", int'(stall_me), 1);
            check_val("frz_bubble_wb", int'(bubble_wb), 1);
            check_val("frz_hold", int'(rs1_src), 1);
            cycle();
        end
        reset_n = 1'b0;
        model_reset();
        set_idle();
        #1;
        check_val("midrst_rs1", int'(rs1_src), 0);
        check_val("midrst_cnt", int'(stall_cnt), 0);
        check_val("midrst_ctrl", obs_ctrl(), 0);
        @(negedge clock);
        reset_n = 1'b1;
        cycle();

        // Counter wrap: 2^CW stall cycles return it to zero
        me_mem_req = 1'b1;
        for (int i = 0; i < (1 << CW); i++) cycle();
        set_idle();
        #1;
        check_val("cnt_wrap", int'(stall_cnt), 0);
        cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            id_rs1_addr     = 5'($urandom_range(0, 3));
            id_rs2_addr     = 5'($urandom_range(0, 3));
            id_rs1_ren      = 1'($urandom_range(0, 1));
            id_rs2_ren      = 1'($urandom_range(0, 1));
            ex_rd_addr      = 5'($urandom_range(0, 3));
            ex_rd_wen       = 1'($urandom_range(0, 1));
            ex_is_load      = 1'($urandom_range(0, 1));
            me_rd_addr      = 5'($urandom_range(0, 3));
            me_rd_wen       = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 3) == 0);
            ex_mdu_valid    = ($urandom_range(0, 3) == 0);
            mdu_done        = ($urandom_range(0, 2) == 0);
            me_mem_req      = ($urandom_range(0, 3) == 0);
            mem_ack         = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Pipeline hazard controller for the five-stage RV64 core. It computes the EX-stage operand forwarding selects (`rs1_src`/`rs2_src`) one cycle early from ID/EX/ME destination tags and registers them into EX. It also sequences per-stage stall, flush and bubble controls for load-use, branch redirect, multi-cycle MDU and data-memory wait. It sits beside the ID/EX/ME pipeline registers and drives both EX operand muxes plus every pipeline-register enable/clear.

## Interface
Parameters:
- `CNT_W`, 32: width of the stall-cycle performance counter.

Ports:
- `clock` input 1: single clock.
- `reset_n` input 1: reset, asynchronous, active-low.
- `id_rs1_addr`, `id_rs2_addr` input 5: source register tags of the instruction in ID.
- `id_rs1_ren`, `id_rs2_ren` input 1: the ID instruction actually reads rs1/rs2.
- `ex_rd_addr` input 5, `ex_rd_wen` input 1, `ex_is_load` input 1: destination of the EX instruction.
- `me_rd_addr` input 5, `me_rd_wen` input 1: destination of the ME instruction.
- `ex_branch_taken` input 1: EX resolved a taken branch/jump.
- `ex_mdu_valid` input 1, `mdu_done` input 1: a multi-cycle mul/div is in EX; result ready.
- `me_mem_req` input 1, `mem_ack` input 1: ME data access outstanding; completed.
- `rs1_src`, `rs2_src` output 2: registered EX forward selects (`RS_EX`/`RS_ME`/`RS_WB`).
- `stall_if`, `stall_id`, `stall_ex`, `stall_me` output 1: hold the PC / corresponding pipeline register.
- `flush_id` output 1: clear the IF/ID register.
- `bubble_ex`, `bubble_me`, `bubble_wb` output 1: load a NOP into that stage's register.
- `stall_cnt` output CNT_W: count of cycles with `stall_if` high.

## Operation
- Forward select, per source `s`, evaluated in ID:
  - `RS_ME` if `id_rs{s}_ren && ex_rd_wen && ex_rd_addr==id_rs{s}_addr && ex_rd_addr!=0`.
  - Else `RS_WB` under the same conditions against `me_rd_*`.
  - Else `RS_EX`.
  - The EX tag has priority (youngest producer).
  - x0 is never forwarded.
- The register file is write-before-read internally. WB→ID bypass is out of scope.
- Load-use hazard: `ex_is_load && ex_rd_wen && ex_rd_addr!=0` and the tag matches an enabled ID source.
- Combinational control, highest priority first:
  1. MEM freeze, when `me_mem_req && !mem_ack`: `stall_if`, `stall_id`, `stall_ex`, `stall_me` all high; `bubble_wb`=1. Everything else is masked.
  2. MDU busy, when `state==MDU_BUSY`, or `state==RUN && ex_mdu_valid && !mdu_done`: `stall_if`, `stall_id`, `stall_ex` high; `bubble_me`=1.
  3. Redirect, when `ex_branch_taken`: `flush_id`=1, `bubble_ex`=1. Load-use is ignored because the ID instruction is killed.
  4. Load-use: `stall_if`, `stall_id` high; `bubble_ex`=1.
- FSM:
  - RUN → MDU_BUSY when `ex_mdu_valid && !mdu_done` and no MEM freeze.
  - MDU_BUSY → RUN on `mdu_done`. `mdu_done` in MDU_BUSY releases the stall in that same cycle.
  - MEM freeze does not change state.
- Select registers:
  - Hold when `stall_ex`.
  - Load `RS_EX` on `bubble_ex`.
  - Otherwise load the ID-computed values.
- After a load-use bubble the load sits in ME when the consumer re-evaluates, so the consumer gets `RS_WB`.
- `stall_cnt` increments each cycle `stall_if`=1 and wraps modulo 2^CNT_W.

## Timing
- Reset, asynchronous while `reset_n` low:
  - `rs1_src`/`rs2_src`=`RS_EX`.
  - `stall_cnt`=0.
  - `state`=RUN.
  - All combinational stall/flush/bubble outputs read 0 when inputs are idle.
- Reset mid-MDU or mid-MEM wait returns to RUN immediately. The held select is lost.
- Select latency: computed in cycle N with the instruction in ID. The value is valid in EX in cycle N+1, aligned with the operand registers.
- Stall/flush/bubble are combinational from the current-cycle inputs and state: zero-cycle response.
- A load-use stall lasts exactly 1 cycle.
- An MDU stall lasts from the first `ex_mdu_valid` cycle through the `mdu_done` cycle, inclusive of release.
- `mem_ack` in the same cycle as `me_mem_req` produces no freeze.
- A MEM freeze overlapping MDU_BUSY keeps MDU_BUSY, and `mdu_done` is still sampled.
- `ex_branch_taken` while `stall_ex` is ignored. The branch re-asserts when EX advances.

## Structure
- `RS_EX`=2'b00, `RS_ME`=2'b01, `RS_WB`=2'b10 and the FSM state encodings belong in the shared `defines.v`. The EX operand muxes use the same select codes.
- One sub-module, `fwd_sel`: the combinational tag comparator for a single source, instantiated twice.

## Test plan
- `add x5` in EX, `sub` reading x5 as rs2 in ID → next cycle `rs2_src`=`RS_ME`. With x5 in ME instead → `RS_WB`. With x5 in both → `RS_ME`. With rd=x0 → `RS_EX`.
- `ld x6` in EX, consumer reads x6 in ID:
  - Cycle N: `stall_if`=`stall_id`=`bubble_ex`=1.
  - Cycle N+1: no stall; the consumer's select becomes `RS_WB` in N+2.
  - `stall_cnt`=1.
- Load-use plus `ex_branch_taken` in the same cycle → `flush_id`=1, `bubble_ex`=1, `stall_if`=0.
- `ex_mdu_valid`=1, `mdu_done` after 4 cycles → `stall_ex`=1 for 4 cycles and `bubble_me` each of them. Released in the `mdu_done` cycle; the state is back to RUN.
- `me_mem_req`=1 and `mem_ack` low for 3 cycles, with a select=`RS_ME` pending → all four stalls plus `bubble_wb` for 3 cycles, and the select stays held. Drop `reset_n` mid-wait → `RS_EX`, RUN, `stall_cnt`=0.
- Preload `stall_cnt`=2^32−1 with one stall cycle → wraps to 0.
